// File: rtl/canvas_pkg.sv
// Shared constants, types and helpers for the canvas RAM scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package canvas_pkg;
    localparam int CANVAS_DIM = 28;
    localparam int CELL_PX    = 14;
    localparam int ORIGIN_X   = 200;
    localparam int ORIGIN_Y   = 44;
    localparam int INK_STEP   = 2000;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 10;
    localparam int NPIX       = CANVAS_DIM * CANVAS_DIM;
    localparam int CANVAS_PX  = CANVAS_DIM * CELL_PX;

    typedef logic [ADDR_W-1:0] canvas_addr_t;
    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [4:0]        cell_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DRAW_RD,
        DRAW_WR,
        STREAM_RD,
        STREAM_OUT
    } sched_state_t;

    // Row-major linear address of a cell.
    function automatic canvas_addr_t cell_addr(input cell_idx_t row, input cell_idx_t col);
        return canvas_addr_t'(row) * canvas_addr_t'(CANVAS_DIM) + canvas_addr_t'(col);
    endfunction

    // Add one ink step, clamping at full scale instead of wrapping.
    function automatic pixel_t add_ink(input pixel_t cur);
        logic [DATA_W:0] sum;
        sum = {1'b0, cur} + (DATA_W+1)'(INK_STEP);
        return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/canvas_hit_map.sv
// Maps a cursor screen position onto a canvas cell (in-canvas flag + RAM address).
// Latency: purely combinational.
// Backpressure: none.
// Ports: X_Pos/Y_Pos cursor screen coordinates; in_canvas high when the cursor
// lies inside the 28x28 cell grid; addr = row*CANVAS_DIM+col (valid only with in_canvas).
module canvas_hit_map
    import canvas_pkg::*;
(
    input  logic [9:0]   X_Pos,
    input  logic [9:0]   Y_Pos,
    output logic         in_canvas,
    output canvas_addr_t addr
);
    logic [9:0] dx;
    logic [9:0] dy;
    cell_idx_t  row;
    cell_idx_t  col;

    // Offsets wrap when the cursor is left of/above the origin; the >= tests mask that.
    assign dx = X_Pos - 10'(ORIGIN_X);
    assign dy = Y_Pos - 10'(ORIGIN_Y);

    assign in_canvas = (X_Pos >= 10'(ORIGIN_X)) && (dx < 10'(CANVAS_PX)) &&
                       (Y_Pos >= 10'(ORIGIN_Y)) && (dy < 10'(CANVAS_PX));

    assign col  = cell_idx_t'(dx / 10'(CELL_PX));
    assign row  = cell_idx_t'(dy / 10'(CELL_PX));
    assign addr = cell_addr(row, col);
endmodule

// File: rtl/canvas_mem_scheduler.sv
// Arbitrates the single-port canvas RAM between clear sweep, brush RMW and NN readout.
// Latency: request->RAM access 2 cycles; clear 784 cycles; draw 2 cycles; stream >= 2 cycles/pixel.
// Backpressure: stream holds pix_data/pix_valid until pix_ready; requests queue as pending flags.
// Ports: frame_clk/Reset (async, active-high); X_Pos/Y_Pos/draw_btn/draw_tick brush input;
// clear_req/infer_req request pulses; ram_* RAM port (sync read, 1-cycle latency);
// pix_* row-major pixel stream to the NN; busy = not idle; infer_done pulses after last pixel.
module canvas_mem_scheduler
    import canvas_pkg::*;
(
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [9:0]        X_Pos,
    input  logic [9:0]        Y_Pos,
    input  logic              draw_btn,
    input  logic              draw_tick,
    input  logic              clear_req,
    input  logic              infer_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              infer_done
);
    sched_state_t state_q, state_d;
    canvas_addr_t addr_q;
    canvas_addr_t drw_cell_q;
    canvas_addr_t hit_addr;
    pixel_t       pix_hold_q;
    logic         hit_in;
    logic         draw_hit;
    logic         clr_p, inf_p, drw_p;
    logic         take_clr, take_inf, take_drw;
    logic         fresh_q;
    logic         infer_done_q;
    logic         beat_done;
    logic         last_pix;

    canvas_hit_map u_hit_map (
        .X_Pos     (X_Pos),
        .Y_Pos     (Y_Pos),
        .in_canvas (hit_in),
        .addr      (hit_addr)
    );

    assign draw_hit  = draw_tick & draw_btn & hit_in;
    assign last_pix  = (addr_q == canvas_addr_t'(NPIX - 1));
    assign beat_done = (state_q == STREAM_OUT) && pix_ready;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            drw_cell_q   <= '0;
            clr_p        <= 1'b0;
            inf_p        <= 1'b0;
            drw_p        <= 1'b0;
            fresh_q      <= 1'b0;
            pix_hold_q   <= '0;
            infer_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // A request arriving in the same cycle its flag is taken re-arms it.
            clr_p <= (clr_p & ~take_clr) | clear_req;
            inf_p <= (inf_p & ~take_inf) | infer_req;
            drw_p <= (drw_p & ~take_drw) | draw_hit;
            if (draw_hit) begin
                drw_cell_q <= hit_addr;
            end
            // Single address counter shared by all operations; seeded on leaving IDLE.
            if (state_q == IDLE) begin
                addr_q <= take_drw ? drw_cell_q : '0;
            end else if (state_q == CLEAR || beat_done) begin
                addr_q <= addr_q + canvas_addr_t'(1);
            end
            // First STREAM_OUT cycle shows RAM data directly; the copy keeps it stable while stalled.
            fresh_q <= (state_q == STREAM_RD);
            if (fresh_q) begin
                pix_hold_q <= ram_rdata;
            end
            infer_done_q <= beat_done && last_pix;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_clr  = 1'b0;
        take_inf  = 1'b0;
        take_drw  = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                if (clr_p) begin
                    take_clr = 1'b1;
                    state_d  = CLEAR;
                end else if (inf_p) begin
                    take_inf = 1'b1;
                    state_d  = STREAM_RD;
                end else if (drw_p) begin
                    take_drw = 1'b1;
                    state_d  = DRAW_RD;
                end
            end
            CLEAR: begin
                ram_addr = addr_q;
                ram_we   = 1'b1;
                if (addr_q == canvas_addr_t'(NPIX - 1)) begin
                    state_d = IDLE;
                end
            end
            DRAW_RD: begin
                ram_addr = addr_q;
                state_d  = DRAW_WR;
            end
            DRAW_WR: begin
                ram_addr  = addr_q;
                ram_we    = 1'b1;
                ram_wdata = add_ink(ram_rdata);
                state_d   = IDLE;
            end
            STREAM_RD: begin
                ram_addr = addr_q;
                state_d  = STREAM_OUT;
            end
            STREAM_OUT: begin
                ram_addr = addr_q;
                if (pix_ready) begin
                    state_d = last_pix ? IDLE : STREAM_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_valid  = (state_q == STREAM_OUT);
    assign pix_last   = pix_valid && last_pix;
    assign pix_data   = pix_valid ? (fresh_q ? ram_rdata : pix_hold_q) : '0;
    assign busy       = (state_q != IDLE);
    assign infer_done = infer_done_q;
endmodule

// File: tb/tb_canvas_mem_scheduler.sv
// Directed bench for canvas_mem_scheduler with a behavioural sync RAM.
// Latency: n/a.
// Backpressure: pix_ready driven by the stimulus sequence.
module tb_canvas_mem_scheduler;
    import canvas_pkg::*;

    logic         frame_clk = 1'b0;
    logic         Reset = 1'b0;
    logic [9:0]   X_Pos = '0;
    logic [9:0]   Y_Pos = '0;
    logic         draw_btn = 1'b0;
    logic         draw_tick = 1'b0;
    logic         clear_req = 1'b0;
    logic         infer_req = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic         ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] pix_data;
    logic         pix_valid;
    logic         pix_ready = 1'b0;
    logic         pix_last;
    logic         busy;
    logic         infer_done;

    always #5 frame_clk = ~frame_clk;

    canvas_mem_scheduler dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .X_Pos      (X_Pos),
        .Y_Pos      (Y_Pos),
        .draw_btn   (draw_btn),
        .draw_tick  (draw_tick),
        .clear_req  (clear_req),
        .infer_req  (infer_req),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .busy       (busy),
        .infer_done (infer_done)
    );

    // Behavioural single-port sync RAM with a bench-only preload port.
    pixel_t       mem [NPIX];
    logic         poke_en = 1'b0;
    canvas_addr_t poke_addr = '0;
    pixel_t       poke_data = '0;
    int           wr_cnt = 0;
    canvas_addr_t last_wr_addr = '0;
    pixel_t       last_wr_data = '0;

    always @(posedge frame_clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_we && ram_addr < ADDR_W'(NPIX)) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_we) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
            last_wr_data <= ram_wdata;
        end
        ram_rdata <= (ram_addr < ADDR_W'(NPIX)) ? mem[ram_addr] : '0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 8) begin
            step(1);
            n++;
        end
        check(tag, 32'(busy), 1);
    endtask

    task automatic draw_at(input logic [9:0] x, input logic [9:0] y);
        X_Pos     = x;
        Y_Pos     = y;
        draw_btn  = 1'b1;
        draw_tick = 1'b1;
        step(1);
        draw_tick = 1'b0;
    endtask

    task automatic poke(input canvas_addr_t a, input pixel_t d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        step(1);
        poke_en   = 1'b0;
    endtask

    // Canvas image expected after the draw section below.
    function automatic pixel_t exp_pix(input int i);
        case (i)
            0, 783:  return 16'd2000;
            89:      return 16'd65535;
            90:      return 16'd65534;
            default: return 16'd0;
        endcase
    endfunction

    logic [9:0] oor_x [3] = '{10'd199, 10'd592, 10'd300};
    logic [9:0] oor_y [3] = '{10'd44,  10'd44,  10'd436};

    initial begin
        int bad, bad_data, bad_stab, bad_last, bad_gap;
        int beats, done_cnt, last_cnt, w0, clr_cycles, c;
        logic   prev_valid, prev_hs;
        pixel_t prev_data;

        // Reset state
        #2 Reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_last", 32'(pix_last), 0);
        check("rst_done", 32'(infer_done), 0);
        step(2);
        Reset = 1'b0;
        step(2);
        check("idle_busy", 32'(busy), 0);

        // Full clear sweep
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        wait_busy("clear_start");
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (!(ram_we === 1'b1 && ram_addr === ADDR_W'(i) && ram_wdata === '0 && busy === 1'b1))
                bad++;
            step(1);
        end
        check("clear_seq", bad, 0);
        check("clear_end_busy", 32'(busy), 0);
        check("clear_end_we", 32'(ram_we), 0);

        // Draw at (207,51) -> cell 0
        draw_at(10'd207, 10'd51);
        wait_busy("draw0_start");
        check("draw0_rd_addr", 32'(ram_addr), 0);
        check("draw0_rd_we", 32'(ram_we), 0);
        step(1);
        check("draw0_wr_we", 32'(ram_we), 1);
        check("draw0_wr_data", 32'(ram_wdata), 2000);
        step(1);
        check("draw0_end_busy", 32'(busy), 0);

        // Saturation at cell 89 (65000 -> 65535) and just below it at cell 90 (63534 -> 65534)
        poke(10'd89, 16'd65000);
        poke(10'd90, 16'd63534);
        draw_at(10'd283, 10'd86);
        wait_busy("sat_start");
        check("sat_rd_addr", 32'(ram_addr), 89);
        step(1);
        check("sat_wr_data", 32'(ram_wdata), 65535);
        step(2);
        draw_at(10'd297, 10'd86);
        wait_busy("near_start");
        step(1);
        check("near_wr_addr", 32'(ram_addr), 90);
        check("near_wr_data", 32'(ram_wdata), 65534);
        step(2);

        // Last in-canvas pixel (591,435) -> cell 783
        draw_at(10'd591, 10'd435);
        wait_busy("corner_start");
        step(1);
        check("corner_wr_addr", 32'(ram_addr), 783);
        check("corner_wr_data", 32'(ram_wdata), 2000);
        step(2);

        // Out-of-canvas ticks: no activity
        for (int v = 0; v < 3; v++) begin
            w0 = wr_cnt;
            draw_at(oor_x[v], oor_y[v]);
            bad = 0;
            for (int k = 0; k < 6; k++) begin
                if (busy) bad++;
                step(1);
            end
            check($sformatf("oor%0d_busy", v), bad, 0);
            check($sformatf("oor%0d_writes", v), wr_cnt - w0, 0);
        end
        draw_btn = 1'b0;

        // Stream with pix_ready toggling
        infer_req = 1'b1;
        step(1);
        infer_req = 1'b0;
        beats = 0; bad_data = 0; bad_stab = 0; bad_last = 0; bad_gap = 0;
        done_cnt = 0; last_cnt = 0;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
        c = 0;
        while (c < 6000 && done_cnt == 0) begin
            pix_ready = c[0];
            if (infer_done) done_cnt++;
            if (pix_valid) begin
                if (prev_valid && !prev_hs && pix_data !== prev_data) bad_stab++;
                if (prev_hs) bad_gap++;
                if (pix_last !== (beats == NPIX - 1)) bad_last++;
                if (pix_ready) begin
                    if (pix_data !== exp_pix(beats)) bad_data++;
                    if (pix_last) last_cnt++;
                    beats++;
                end
            end
            prev_hs    = pix_valid && pix_ready;
            prev_valid = pix_valid;
            prev_data  = pix_data;
            step(1);
            c++;
        end
        for (int k = 0; k < 5; k++) begin
            if (infer_done) done_cnt++;
            step(1);
        end
        check("strm_beats", beats, NPIX);
        check("strm_data", bad_data, 0);
        check("strm_stable", bad_stab, 0);
        check("strm_gap", bad_gap, 0);
        check("strm_last_flag", bad_last, 0);
        check("strm_last_cnt", last_cnt, 1);
        check("strm_done_cnt", done_cnt, 1);
        check("strm_end_busy", 32'(busy), 0);

        // clear+infer together, draw during stream deferred
        X_Pos = 10'd207; Y_Pos = 10'd51; draw_btn = 1'b1;
        clear_req = 1'b1; infer_req = 1'b1;
        step(1);
        clear_req = 1'b0; infer_req = 1'b0;
        wait_busy("both_start");
        clr_cycles = 0;
        c = 0;
        while (c < 1000 && ram_we) begin
            if (ram_wdata === '0) clr_cycles++;
            step(1);
            c++;
        end
        check("both_clear_len", clr_cycles, NPIX);
        pix_ready = 1'b1;
        w0 = wr_cnt;
        beats = 0; bad_data = 0; done_cnt = 0;
        c = 0;
        while (c < 4000 && done_cnt == 0) begin
            draw_tick = (c == 40);
            if (infer_done) done_cnt++;
            if (pix_valid) begin
                if (pix_data !== '0) bad_data++;
                beats++;
            end
            step(1);
            c++;
        end
        draw_tick = 1'b0;
        check("both_beats", beats, NPIX);
        check("both_zero", bad_data, 0);
        check("both_no_wr_in_strm", wr_cnt - w0, 0);
        step(6);
        check("deferred_wr_cnt", wr_cnt - w0, 1);
        check("deferred_wr_addr", 32'(last_wr_addr), 0);
        check("deferred_wr_data", 32'(last_wr_data), 2000);

        // Reset mid-stream at beat 300 with clear and draw pending
        infer_req = 1'b1;
        step(1);
        infer_req = 1'b0;
        beats = 0;
        c = 0;
        while (c < 3000 && !(pix_valid && beats == 300)) begin
            draw_tick = (c == 5);
            clear_req = (c == 7);
            if (pix_valid) beats++;
            step(1);
            c++;
        end
        draw_tick = 1'b0;
        clear_req = 1'b0;
        check("rst_mid_valid_before", 32'(pix_valid), 1);
        Reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_valid", 32'(pix_valid), 0);
        check("rst_mid_data", 32'(pix_data), 0);
        check("rst_mid_we", 32'(ram_we), 0);
        check("rst_mid_addr", 32'(ram_addr), 0);
        step(2);
        Reset = 1'b0;
        w0 = wr_cnt;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || pix_valid || infer_done) bad++;
            step(1);
        end
        check("post_rst_idle", bad, 0);
        check("post_rst_writes", wr_cnt - w0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
